mem_stage_dport: RTL
====================

# mem_stage_dport

Data-memory responder for the MEM stage. It accepts the load/store request driven by the EX/MEM pipeline register (commit-gated `mem_read`/`mem_write`, ALU address, raw rs2 data, funct3) and runs it against the data-memory port with a request/response handshake. It aligns store data and generates byte enables, stalls the pipeline until memory responds, and returns sign/zero-extended load data to MEM/WB.

## Interface
Parameters: none.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. Asynchronous, active-high.
- `mem_read` in 1: load request, already commit-gated upstream.
- `mem_write` in 1: store request, already commit-gated upstream.
- `funct3` in 3: access size/sign. Loads: lb 000, lh 001, lw 010, lbu 100, lhu 101. Stores: sb 000, sh 001, sw 010.
- `mem_addr` in 32: byte address (ALU result).
- `mem_wdata` in 32: unshifted rs2 value.
- `stall` out 1: hold all pipeline register loads low while 1.
- `misaligned` out 1: combinational trap flag for the current request.
- `load_data` out 32: extended load result.
- `rmask`, `wmask` out 4 each: byte masks for the monitor.
- `dmem_read`, `dmem_write` out 1 each: memory strobes.
- `dmem_address` out 32: word-aligned address, `{mem_addr[31:2],2'b00}`.
- `dmem_wdata` out 32: lane-shifted store data.
- `dmem_byte_enable` out 4: write byte lanes.
- `dmem_rdata` in 32: read data.
- `dmem_resp` in 1: single-cycle completion pulse.
- `stall_cycles` out 32: count of cycles with `stall`=1.

## Operation
- Request present: `req = mem_read | mem_write`. If both are high, the access is treated as a read and the write is ignored.
- Offset `o = mem_addr[1:0]`.
- Misalignment rules: word access with `o!=0`, or half access with `o[0]!=0`, sets `misaligned=1`.
  - No dmem access is made, `stall=0`, and no capture occurs.
- Masks:
  - Word: 1111.
  - Half: 0011 << {o[1],0}.
  - Byte: 0001 << o.
  - Any funct3 outside the table is a word access.
  - `rmask` is valid for loads and `wmask` for stores; the unused mask is 0000.
- `dmem_wdata = mem_wdata << (8*o)`.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: on `req & ~misaligned`, register address, wdata, byte enable, direction and funct3, then go to BUSY. `dmem_resp` is ignored in IDLE.
  - BUSY: drive `dmem_*` from the registered values. Hold them stable until `dmem_resp`. On `dmem_resp`, capture `dmem_rdata` (loads only) and go to DONE.
  - DONE: one cycle, then unconditionally go to IDLE. The upstream register advances at the end of DONE, so the same request is never re-issued.
- `stall = (IDLE & req & ~misaligned) | BUSY`. `stall` is 0 in DONE.
- Load extension: `s = captured >> (8*o_reg)`.
  - lb: sext(s[7:0]). lbu: zext(s[7:0]).
  - lh: sext(s[15:0]). lhu: zext(s[15:0]).
  - lw: s.
- `load_data` holds its value until the next load capture.
- `stall_cycles` increments by 1 on each cycle with `stall=1` and wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values:
  - State IDLE.
  - `dmem_read`, `dmem_write` = 0.
  - `dmem_address`, `dmem_wdata`, `dmem_byte_enable` = 0.
  - `load_data` = 0, `stall_cycles` = 0.
  - `stall`, `misaligned`, `rmask`, `wmask` are combinational from inputs and state.
- Request sampled in IDLE at cycle 0:
  - Strobe asserted from cycle 1.
  - `dmem_resp` at cycle k≥1 gives DONE at k+1, with `load_data` valid and `stall=0` at k+1.
- Minimum occupancy is 3 cycles, of which 2 are stalled. Back-to-back requests restart from IDLE at k+2.
- Strobe deasserts in the cycle after `dmem_resp`.
- Reset mid-BUSY:
  - Strobes drop immediately (asynchronously) and the FSM returns to IDLE.
  - A late `dmem_resp` after reset is ignored.

## Test plan
- lw at 0x100; memory returns 0xDEADBEEF after 3 BUSY cycles -> `dmem_address`=0x100, `rmask`=1111, `stall` high for 4 cycles, `load_data`=0xDEADBEEF in DONE, `stall_cycles`=4.
- lb/lbu at 0x103 with rdata 0x80112233 -> lb gives 0xFFFFFF80, lbu gives 0x00000080, `rmask`=1000.
- sh at 0x202 with rs2=0x0000ABCD -> `dmem_wdata`=0xABCD0000, `dmem_byte_enable`=1100, `dmem_address`=0x200, `wmask`=1100.
- lw at 0x101 -> `misaligned`=1, `stall`=0, no `dmem_read`, `load_data` unchanged.
- Back-to-back sb 0x3 then lw 0x4, each with `dmem_resp` in the first BUSY cycle -> each occupies IDLE/BUSY/DONE, `dmem_byte_enable`=1000 for the first, no duplicate strobe, total stall 4.
- Assert `rst` during BUSY, then pulse `dmem_resp` -> strobes 0 immediately, state IDLE, `load_data`=0, the late response ignored.

Source files
------------

// File: rtl/mem_stage_dport.sv
// ---------------------------------------------------------------------------
// mem_stage_dport
//
// Data-memory responder for the MEM stage. Takes the commit-gated load/store
// request from the EX/MEM register, runs it against the data-memory port with
// a request/response handshake, stalls the pipeline until memory answers and
// returns the sign/zero-extended load result to MEM/WB.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   mem_read/mem_write  load/store request (read wins if both are set)
//   funct3              access size/sign (lb/lh/lw/lbu/lhu, sb/sh/sw)
//   mem_addr            byte address from the ALU
//   mem_wdata           unshifted rs2 store value
//   stall               holds pipeline register loads while 1
//   misaligned          combinational trap flag for the current request
//   load_data           extended load result, held until the next load
//   rmask/wmask         byte masks for the monitor
//   dmem_read/write     memory strobes
//   dmem_address        word-aligned address
//   dmem_wdata          lane-shifted store data
//   dmem_byte_enable    write byte lanes
//   dmem_rdata          memory read data
//   dmem_resp           single-cycle completion pulse
//   stall_cycles        free-running count of stalled cycles (wraps)
// ---------------------------------------------------------------------------
module mem_stage_dport (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        stall,
    output logic        misaligned,
    output logic [31:0] load_data,
    output logic [3:0]  rmask,
    output logic [3:0]  wmask,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_enable,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t      state_q;
    logic        rd_q;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [31:0] load_data_q;
    logic [31:0] load_data_d;
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    logic        req;
    logic        is_load;
    logic        is_store;
    logic [1:0]  off;
    logic        is_byte;
    logic        is_half;
    logic [3:0]  acc_mask;
    logic        start;
    logic [31:0] shifted_rdata;

    // A simultaneous read and write is treated as a read only.
    assign req      = mem_read | mem_write;
    assign is_load  = mem_read;
    assign is_store = mem_write & ~mem_read;
    assign off      = mem_addr[1:0];

    // Size decode. Load and store tables differ (100/101 are only valid for
    // loads), and anything outside a table falls back to a word access.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        if (is_load) begin
            case (funct3)
                3'b000, 3'b100: is_byte = 1'b1;
                3'b001, 3'b101: is_half = 1'b1;
                default:        ;
            endcase
        end else begin
            case (funct3)
                3'b000:  is_byte = 1'b1;
                3'b001:  is_half = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        acc_mask = 4'b1111;
        if (is_byte) begin
            acc_mask = 4'b0001 << off;
        end else if (is_half) begin
            acc_mask = 4'b0011 << {off[1], 1'b0};
        end
    end

    assign misaligned = req & (((~is_byte & ~is_half) & (off != 2'b00)) |
                               (is_half & off[0]));

    assign rmask = is_load  ? acc_mask : 4'b0000;
    assign wmask = is_store ? acc_mask : 4'b0000;

    // Accept a new request only from IDLE; DONE deliberately drops stall so
    // the upstream register advances and the request is not re-issued.
    assign start = (state_q == ST_IDLE) & req & ~misaligned;
    assign stall = start | (state_q == ST_BUSY);

    // Load extension works on the captured word shifted down to lane 0.
    assign shifted_rdata = dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        load_data_d = shifted_rdata;
        case (f3_q)
            3'b000:  load_data_d = {{24{shifted_rdata[7]}},  shifted_rdata[7:0]};
            3'b100:  load_data_d = {24'd0,                   shifted_rdata[7:0]};
            3'b001:  load_data_d = {{16{shifted_rdata[15]}}, shifted_rdata[15:0]};
            3'b101:  load_data_d = {16'd0,                   shifted_rdata[15:0]};
            default: load_data_d = shifted_rdata;
        endcase
    end

    assign stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            be_q        <= 4'd0;
            off_q       <= 2'd0;
            f3_q        <= 3'd0;
            load_data_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            case (state_q)
                ST_IDLE: begin
                    // dmem_resp is ignored here: a stray pulse cannot complete
                    // anything that was not issued.
                    if (start) begin
                        rd_q    <= is_load;
                        wr_q    <= is_store;
                        addr_q  <= {mem_addr[31:2], 2'b00};
                        wdata_q <= mem_wdata << {off, 3'b000};
                        be_q    <= wmask;
                        off_q   <= off;
                        f3_q    <= funct3;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (dmem_resp) begin
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        if (rd_q) begin
                            load_data_q <= load_data_d;
                        end
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dmem_read        = rd_q;
    assign dmem_write       = wr_q;
    assign dmem_address     = addr_q;
    assign dmem_wdata       = wdata_q;
    assign dmem_byte_enable = be_q;
    assign load_data        = load_data_q;
    assign stall_cycles     = stall_cnt_q;

endmodule
